// File: rtl/pipeline_control.sv
// -----------------------------------------------------------------------------
// pipeline_control
//   Central sequencer for the 5-stage integer pipeline (F, D, X, M, W).
//   It owns the fetch PC and drives every pipeline-register enable and flush.
//   Each cycle it turns the load-use bubble, taken jumps and I/D-cache stalls
//   into a single stall/flush/redirect decision.
//
//   Optional feature macro: PIPE_CTRL_PERF_EN
//     defined   -> three wrapping 32-bit performance counters.
//     undefined -> the counter outputs are tied to 0 and perf_clr is ignored.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   bubble                            Execute load-use hazard
//   do_jump, jump_target[31:0]        Execute resolved a taken jump, and its target
//   icache_stall, dcache_stall        cache miss stalls
//   pc[31:0]                          fetch address (register)
//   fd_we, dx_we, xm_we, mw_we        pipeline-register enables
//   fd_flush, dx_flush, xm_flush      load a NOP (only takes effect with the matching _we)
//   perf_clr                          clear the performance counters
//   cycle_cnt, stall_cnt, flush_cnt   performance counters
// -----------------------------------------------------------------------------
module pipeline_control #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bubble,
    input  logic        do_jump,
    input  logic [31:0] jump_target,
    input  logic        icache_stall,
    input  logic        dcache_stall,
    output logic [31:0] pc,
    output logic        fd_we,
    output logic        dx_we,
    output logic        xm_we,
    output logic        mw_we,
    output logic        fd_flush,
    output logic        dx_flush,
    output logic        xm_flush,
    input  logic        perf_clr,
    output logic [31:0] cycle_cnt,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic [31:0] pend_target_r;
    logic [31:0] pend_target_next_s;
    logic [31:0] jump_tgt_s;
    logic        stall_evt_s;
    logic        flush_evt_s;

    // Jump targets are halfword aligned; bit 0 is always forced to zero.
    assign jump_tgt_s = {jump_target[31:1], 1'b0};
    assign pc         = pc_r;

    // Priority decision: enables, flushes and next-state values.
    always_comb begin
        state_next_s       = state_r;
        pc_next_s          = pc_r;
        pend_target_next_s = pend_target_r;
        fd_we              = 1'b1;
        dx_we              = 1'b1;
        xm_we              = 1'b1;
        mw_we              = 1'b1;
        fd_flush           = 1'b0;
        dx_flush           = 1'b0;
        xm_flush           = 1'b0;
        stall_evt_s        = 1'b0;
        flush_evt_s        = 1'b0;

        if (rst) begin
            // Fill the whole pipeline with NOPs while reset is held.
            fd_flush = 1'b1;
            dx_flush = 1'b1;
            xm_flush = 1'b1;
        end else if (dcache_stall) begin
            // A D-cache miss freezes everything, including a pending redirect.
            fd_we       = 1'b0;
            dx_we       = 1'b0;
            xm_we       = 1'b0;
            mw_we       = 1'b0;
            stall_evt_s = 1'b1;
        end else if (state_r == ST_PEND) begin
            // Whatever the I-cache delivers here is from the wrong path.
            // On the cycle icache_stall falls, that instruction is dropped
            // and the pending target goes out.
            fd_flush = 1'b1;
            if (icache_stall) begin
                stall_evt_s = 1'b1;
            end else begin
                pc_next_s    = pend_target_r;
                state_next_s = ST_RUN;
            end
        end else if (bubble) begin
            // do_jump is ignored here because its operands are stale.
            // Execute re-evaluates it next cycle.
            fd_we       = 1'b0;
            dx_we       = 1'b0;
            xm_flush    = 1'b1;
            stall_evt_s = 1'b1;
        end else if (do_jump) begin
            fd_flush    = 1'b1;
            dx_flush    = 1'b1;
            flush_evt_s = 1'b1;
            if (icache_stall) begin
                pend_target_next_s = jump_tgt_s;
                state_next_s       = ST_PEND;
            end else begin
                pc_next_s = jump_tgt_s;
            end
        end else if (icache_stall) begin
            fd_flush    = 1'b1;
            stall_evt_s = 1'b1;
        end else begin
            pc_next_s = pc_r + PC_STEP;
        end
    end

    // State, PC and pending-redirect registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_RUN;
            pc_r          <= RESET_PC;
            pend_target_r <= 32'd0;
        end else begin
            state_r       <= state_next_s;
            pc_r          <= pc_next_s;
            pend_target_r <= pend_target_next_s;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] cycle_cnt_r;
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Wrapping performance counters. A clear takes priority over an increment.
    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            cycle_cnt_r <= 32'd0;
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            cycle_cnt_r <= cycle_cnt_r + 32'd1;
            stall_cnt_r <= stall_cnt_r + {31'd0, stall_evt_s};
            flush_cnt_r <= flush_cnt_r + {31'd0, flush_evt_s};
        end
    end

    assign cycle_cnt = cycle_cnt_r;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`else
    logic unused_perf_s;
    assign unused_perf_s = perf_clr ^ stall_evt_s ^ flush_evt_s;
    assign cycle_cnt     = 32'd0;
    assign stall_cnt     = 32'd0;
    assign flush_cnt     = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// -----------------------------------------------------------------------------
// tb_pipeline_control
//   Self-checking bench for pipeline_control. It runs directed scenarios and
//   then random traffic. Each cycle it compares the DUT outputs with a
//   behavioural model (fetch address, redirect-pending flag and target,
//   event counts) that the bench builds directly from the priority rules.
// -----------------------------------------------------------------------------
module tb_pipeline_control;

    localparam logic [31:0] RST_PC = 32'h4000_0000;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bubble = 1'b0;
    logic        do_jump = 1'b0;
    logic [31:0] jump_target = 32'd0;
    logic        icache_stall = 1'b0;
    logic        dcache_stall = 1'b0;
    logic        perf_clr = 1'b0;
    logic [31:0] pc;
    logic        fd_we, dx_we, xm_we, mw_we;
    logic        fd_flush, dx_flush, xm_flush;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_pend;
    logic [31:0] m_tgt;
    int unsigned m_cyc, m_stall, m_flush;

    pipeline_control dut (
        .clk(clk), .rst(rst), .bubble(bubble), .do_jump(do_jump),
        .jump_target(jump_target), .icache_stall(icache_stall),
        .dcache_stall(dcache_stall), .pc(pc),
        .fd_we(fd_we), .dx_we(dx_we), .xm_we(xm_we), .mw_we(mw_we),
        .fd_flush(fd_flush), .dx_flush(dx_flush), .xm_flush(xm_flush),
        .perf_clr(perf_clr), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive the inputs, check the outputs against the model,
    // then advance the model across the rising edge.
    task automatic cycle(input logic r, input logic b, input logic j,
                         input logic [31:0] t, input logic is, input logic ds,
                         input logic clr);
        logic [3:0]  e_we;
        logic [2:0]  e_fl;
        logic [31:0] n_pc, n_tgt;
        bit          n_pend, st, fl;
        @(negedge clk);
        rst = r; bubble = b; do_jump = j; jump_target = t;
        icache_stall = is; dcache_stall = ds; perf_clr = clr;
        #1;
        e_we = 4'b1111; e_fl = 3'b000;
        n_pc = m_pc; n_pend = m_pend; n_tgt = m_tgt; st = 1'b0; fl = 1'b0;
        if (r) begin
            e_fl = 3'b111; n_pc = RST_PC; n_pend = 1'b0; n_tgt = 32'd0;
        end else if (ds) begin
            e_we = 4'b0000; st = 1'b1;
        end else if (m_pend) begin
            e_fl = 3'b100;
            if (is) st = 1'b1;
            else begin n_pc = m_tgt; n_pend = 1'b0; end
        end else if (b) begin
            e_we = 4'b0011; e_fl = 3'b001; st = 1'b1;
        end else if (j) begin
            e_fl = 3'b110; fl = 1'b1;
            if (is) begin n_pend = 1'b1; n_tgt = t & 32'hFFFF_FFFE; end
            else n_pc = t & 32'hFFFF_FFFE;
        end else if (is) begin
            e_fl = 3'b100; st = 1'b1;
        end else begin
            n_pc = m_pc + 32'd4;
        end
        chk("pc", pc, m_pc);
        chk("we", {28'd0, fd_we, dx_we, xm_we, mw_we}, {28'd0, e_we});
        chk("flush", {29'd0, fd_flush, dx_flush, xm_flush}, {29'd0, e_fl});
        chk("cycle_cnt", cycle_cnt, PERF ? m_cyc : 32'd0);
        chk("stall_cnt", stall_cnt, PERF ? m_stall : 32'd0);
        chk("flush_cnt", flush_cnt, PERF ? m_flush : 32'd0);
        @(posedge clk);
        #1;
        m_pc = n_pc; m_pend = n_pend; m_tgt = n_tgt;
        if (r || clr) begin
            m_cyc = 0; m_stall = 0; m_flush = 0;
        end else begin
            m_cyc++; m_stall += st; m_flush += fl;
        end
    endtask

    initial begin
        m_pc = 32'd0; m_pend = 1'b0; m_tgt = 32'd0;
        m_cyc = 0; m_stall = 0; m_flush = 0;

        // Reset: the first cycle only checks the enables and flushes, because
        // pc is undefined before the first reset edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_we", {28'd0, fd_we, dx_we, xm_we, mw_we}, 32'd15);
        chk("rst_flush", {29'd0, fd_flush, dx_flush, xm_flush}, 32'd7);
        @(posedge clk);
        #1;
        m_pc = RST_PC;
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("reset_pc", pc, 32'h4000_0000);

        // Free running, then a one-cycle bubble at 4000_0008.
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("pc_seq", pc, 32'h4000_0008);
        cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("bubble_hold", pc, 32'h4000_0008);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("after_bubble", pc, 32'h4000_000C);

        // Jump with no I-cache miss.
        cycle(1'b0, 1'b0, 1'b1, 32'h4000_0101, 1'b0, 1'b0, 1'b0);
        chk("jump_pc", pc, 32'h4000_0100);

        // Jump during an I-cache miss: the redirect waits in PEND.
        cycle(1'b0, 1'b0, 1'b1, 32'h4000_0200, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("pend_hold", pc, 32'h4000_0100);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("pend_exit", pc, 32'h4000_0200);

        // D-cache freeze overrides bubble and jump.
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b1, 1'b1, 32'h5000_0000, 1'b0, 1'b1, 1'b0);
        chk("dstall_hold", pc, 32'h4000_0200);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("dstall_resume", pc, 32'h4000_0204);

        // PC wraps from FFFF_FFFC to 0.
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("pc_wrap", pc, 32'h0000_0000);

        // Reset in the middle of PEND drops the pending target.
        cycle(1'b0, 1'b0, 1'b1, 32'h6000_0000, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("rst_mid_pend", pc, 32'h4000_0004);

        // Perf window: clear, then 10 cycles with 2 bubbles and 1 jump.
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++)
            cycle(1'b0, (i == 2 || i == 5), (i == 7), 32'h4000_0040, 1'b0, 1'b0, 1'b0);
        #2;
        chk("perf_cycle", cycle_cnt, PERF ? 32'd10 : 32'd0);
        chk("perf_stall", stall_cnt, PERF ? 32'd2 : 32'd0);
        chk("perf_flush", flush_cnt, PERF ? 32'd1 : 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        #2;
        chk("perf_clr", cycle_cnt | stall_cnt | flush_cnt, 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 4) == 0), $urandom,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0),
                  ($urandom_range(0, 39) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
